uart_rx_mmio: RTL and testbench

- Memory-mapped UART receiver (8N1), the receive-side counterpart of the existing UART transmit MMIO peripheral.
- Samples an asynchronous serial line, assembles bytes and buffers them in a small FIFO.
- Exposes data and status registers on the CPU data port.
- Read data is combinational from registered state only, so single-cycle LOADs create no combinational loop.

---
 rtl/uart_rx_mmio.sv | 156 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// Data and status registers are read combinationally from registered state.
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        re,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        irq
);

    localparam int CCW = $clog2(CLKS_PER_BIT);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CCW-1:0] HALF   = CCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CCW-1:0] LAST   = CCW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0]  FULL_N = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [CCW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           frame_end;

    logic rx_meta, rx_s, rx_prev;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          ovr_q, ferr_q;

    logic empty, full, pop, push, ovr_set, ferr_set, clr;
    logic [3:0] cnt4;
    logic unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev && !rx_s) state_d = START;
            end
            START: begin
                // Mid-start-bit check rejects short glitches
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == LAST) begin
                    clk_cnt_d = '0;
                    frame_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty    = (count == '0);
    assign full     = (count == FULL_N);
    assign pop      = sel && re && (addr[3:2] == 2'd0) && !empty;
    // A pop in the same cycle frees the slot the new byte needs
    assign push     = frame_end && rx_s && (!full || pop);
    assign ovr_set  = frame_end && rx_s && full && !pop;
    assign ferr_set = frame_end && !rx_s;
    assign clr      = sel && we && (addr[3:2] == 2'd1) && wstrb[0];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count + NW'(push) - NW'(pop);
            ovr_q  <= ovr_set  | (ovr_q  & ~(clr & wdata[2]));
            ferr_q <= ferr_set | (ferr_q & ~(clr & wdata[3]));
        end
    end

    assign cnt4 = 4'(count);
    assign irq  = !empty;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                2'd0: if (!empty) rdata[7:0] = mem[rd_ptr];
                2'd1: rdata[7:0] = {cnt4, ferr_q, ovr_q, full, !empty};
                default: rdata = '0;
            endcase
        end
    end

    assign unused = ^{addr[1:0], wstrb[3:1], wdata[31:4], wdata[1:0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomized and directed bench for uart_rx_mmio against a queue-based
// model of the receive FIFO and its sticky error flags.
module tb_uart_rx_mmio;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, re, we, rx;
    logic [3:0]  addr, wstrb;
    logic [31:0] wdata, rdata;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    byte unsigned mq[$];
    bit m_ovr, m_ferr;

    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sel(sel), .re(re), .we(we),
        .addr(addr), .wstrb(wstrb), .wdata(wdata), .rdata(rdata),
        .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_status();
        int c = mq.size();
        return {24'b0, 4'(c), m_ferr, m_ovr, c == DEPTH, c != 0};
    endfunction

    function automatic void model_frame(byte unsigned b, bit stop);
        if (!stop) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; re = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        sel = 1'b0; re = 1'b0; addr = 4'h0;
    endtask

    task automatic status_check(string tag);
        logic [31:0] d;
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, mq.size() != 0});
        read_reg(4'h4, d);
        check({tag, "_status"}, d, exp_status());
    endtask

    task automatic pop_check(string tag);
        logic [31:0] d, e;
        e = 0;
        if (mq.size() != 0) e = {24'b0, mq.pop_front()};
        read_reg(4'h0, d);
        check(tag, d, e);
    endtask

    task automatic w1c(logic [31:0] wd);
        sel = 1'b1; we = 1'b1; addr = 4'h4; wstrb = 4'h1; wdata = wd;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wstrb = 4'h0; wdata = '0;
        if (wd[2]) m_ovr = 1'b0;
        if (wd[3]) m_ferr = 1'b0;
    endtask

    // Drives up to nper bit periods of a frame; a full frame adds idle time
    task automatic drive_frame(byte unsigned b, bit stop, int nper);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10 && i < nper; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (nper >= 10) begin
            rx = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send(byte unsigned b, bit stop);
        drive_frame(b, stop, 10);
        model_frame(b, stop);
    endtask

    initial begin
        logic [31:0] d, popd;
        byte unsigned head;
        rst = 1'b1; sel = 1'b0; re = 1'b0; we = 1'b0;
        addr = 4'h0; wstrb = 4'h0; wdata = '0; rx = 1'b1;
        m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        status_check("idle");

        send(8'hA5, 1'b1);
        read_reg(4'h4, d);
        check("a5_status", d, 32'h11);
        check("a5_irq", {31'b0, irq}, 32'h1);
        pop_check("a5_data");
        status_check("a5_after");

        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        status_check("glitch");

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        read_reg(4'h4, d);
        check("ovr_status", d, 32'h47);
        for (int i = 0; i < 4; i++) pop_check("ovr_data");
        w1c(32'h4);
        status_check("ovr_clr");

        send(8'h3C, 1'b0);
        read_reg(4'h4, d);
        check("ferr_status", d, 32'h08);
        w1c(32'h8);
        status_check("ferr_clr");
        send(8'h3C, 1'b1);
        pop_check("ferr_next");

        sel = 1'b1; we = 1'b1; addr = 4'h8; wstrb = 4'hF; wdata = '1;
        @(negedge clk);
        we = 1'b0; re = 1'b1;
        #1 check("reg8", rdata, 32'h0);
        addr = 4'hC;
        #1 check("regc", rdata, 32'h0);
        @(negedge clk);
        sel = 1'b0; re = 1'b0; addr = 4'h0; wstrb = 4'h0; wdata = '0;
        send(8'h99, 1'b1);
        re = 1'b1; addr = 4'h4;
        #1 check("nosel", rdata, 32'h0);
        @(negedge clk);
        re = 1'b0;
        status_check("nosel_st");
        pop_check("nosel_data");

        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1'b1);
        fork
            drive_frame(8'h77, 1'b1, 10);
            begin
                repeat (78) @(negedge clk);
                sel = 1'b1; re = 1'b1; addr = 4'h0;
                #1 popd = rdata;
                @(negedge clk);
                sel = 1'b0; re = 1'b0;
            end
        join
        head = mq.pop_front();
        check("simul_pop", popd, {24'b0, head});
        model_frame(8'h77, 1'b1);
        status_check("simul");
        for (int i = 0; i < 4; i++) pop_check("simul_data");

        send(8'h11, 1'b1);
        drive_frame(8'hC3, 1'b1, 4);
        rst = 1'b1; rx = 1'b1;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        sel = 1'b1; addr = 4'h4;
        #1;
        check("midrst_irq", {31'b0, irq}, 32'h0);
        check("midrst_st", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; addr = 4'h0;
        repeat (100) @(negedge clk);
        status_check("midrst_idle");
        send(8'h5A, 1'b1);
        pop_check("midrst_5a");

        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 5) send(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
            else if (r < 8) pop_check("rnd_data");
            else if (r == 8) w1c({28'b0, 2'($urandom_range(0, 3)), 2'b0});
            else repeat (3) @(negedge clk);
            status_check("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
